tow_scorer: RTL and testbench

TOW_SCORER -- requirements
Module: tow_scorer

---
 rtl/tow_scorer.sv | 93 +++++++++
 tb/tb_tow_scorer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tow_scorer.sv
// Tug-of-war round scorer: tracks rope position, pulses winrnd per decided round.
// winrnd and pos update on the deciding edge; leds lag inputs/pos by one cycle; no backpressure.
module tow_scorer #(
   parameter int GOAL = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pbl,
   input  logic             pbr,
   input  logic             leds_on,
   input  logic [1:0]       led_ctrl,
   input  logic             clr,
   output logic             winrnd,
   output logic [2*GOAL:0]  leds
);

   localparam int PW = $clog2(GOAL + 1) + 1;
   localparam logic signed [PW-1:0] POS_MAX = PW'(GOAL);
   localparam logic signed [PW-1:0] POS_MIN = -POS_MAX;

   typedef enum logic [1:0] {HOLD, ARMED, SCORED, MATCH} state_t;

   state_t                 state;
   logic signed [PW-1:0]   pos;
   logic signed [PW-1:0]   pos_up;
   logic signed [PW-1:0]   pos_dn;
   logic                   play;
   logic                   dark;
   logic                   left_win;
   logic                   right_win;
   logic [2*GOAL:0]        rope;

   always_comb begin
      play      = leds_on && ((led_ctrl == 2'b10) || (led_ctrl == 2'b01));
      dark      = (led_ctrl == 2'b00);
      // In the dark phase a press is a false start and hands the round to the opponent.
      left_win  = (play && pbl && !pbr) || (dark && pbr && !pbl);
      right_win = (play && pbr && !pbl) || (dark && pbl && !pbr);
      pos_up    = pos + PW'(1);
      pos_dn    = pos - PW'(1);
      rope      = {{(2*GOAL){1'b0}}, 1'b1} << (GOAL + int'(pos));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= HOLD;
         pos    <= '0;
         winrnd <= 1'b0;
         leds   <= '0;
      end else begin
         winrnd <= 1'b0;

         if (!leds_on)
            leds <= '0;
         else if (led_ctrl == 2'b11)
            leds <= '1;
         else if (led_ctrl == 2'b00)
            leds <= '0;
         else
            leds <= rope;

         case (state)
            HOLD: begin
               if (!clr)
                  state <= ARMED;
            end
            ARMED: begin
               // A hold request wins over a press arriving in the same cycle.
               if (clr) begin
                  state <= HOLD;
               end else if (left_win) begin
                  pos    <= pos_dn;
                  winrnd <= 1'b1;
                  state  <= (pos_dn == POS_MIN) ? MATCH : SCORED;
               end else if (right_win) begin
                  pos    <= pos_up;
                  winrnd <= 1'b1;
                  state  <= (pos_up == POS_MAX) ? MATCH : SCORED;
               end
            end
            SCORED: begin
               if (clr)
                  state <= HOLD;
            end
            MATCH: begin
               state <= MATCH;
            end
            default: state <= HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_tow_scorer.sv
// Directed bench for tow_scorer (GOAL=3) with an expectation queue per clock step.
module tb_tow_scorer;

   localparam logic [1:0] PLAY = 2'b10;
   localparam logic [1:0] DARK = 2'b00;
   localparam logic [1:0] ALL  = 2'b11;
   localparam logic [1:0] ALT  = 2'b01;
   localparam int S_HOLD   = 0;
   localparam int S_ARMED  = 1;
   localparam int S_SCORED = 2;
   localparam int S_MATCH  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pbl = 1'b0;
   logic       pbr = 1'b0;
   logic       leds_on = 1'b1;
   logic [1:0] led_ctrl = PLAY;
   logic       clr = 1'b1;
   logic       winrnd;
   logic [6:0] leds;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       w;
      int         p;
      logic [6:0] l;
      int         s;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   tow_scorer #(.GOAL(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .pbl      (pbl),
      .pbr      (pbr),
      .leds_on  (leds_on),
      .led_ctrl (led_ctrl),
      .clr      (clr),
      .winrnd   (winrnd),
      .leds     (leds)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue what must be seen after the edge, then compare.
   task automatic step(input logic r, input logic l, input logic rr, input logic c,
                       input logic on, input logic [1:0] m,
                       input logic ew, input int ep, input logic [6:0] el, input int es,
                       input string tag);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst = r; pbl = l; pbr = rr; clr = c; leds_on = on; led_ctrl = m;
      e.w = ew; e.p = ep; e.l = el; e.s = es; e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      checks++;
      assert (winrnd === got.w) else begin
         failures++;
         $error("FAIL %s winrnd got=%0b exp=%0b", got.tag, winrnd, got.w);
      end
      checks++;
      assert (int'(dut.pos) === got.p) else begin
         failures++;
         $error("FAIL %s pos got=%0d exp=%0d", got.tag, int'(dut.pos), got.p);
      end
      checks++;
      assert (leds === got.l) else begin
         failures++;
         $error("FAIL %s leds got=%b exp=%b", got.tag, leds, got.l);
      end
      checks++;
      assert (int'(dut.state) === got.s) else begin
         failures++;
         $error("FAIL %s state got=%0d exp=%0d", got.tag, int'(dut.state), got.s);
      end
   endtask

   initial begin
      //    rst pbl pbr clr on ctrl  win pos leds        state
      step(0, 0, 0, 1, 1, PLAY, 0,  0, 7'b0000000, S_HOLD,   "reset");
      step(1, 0, 0, 0, 1, PLAY, 0,  0, 7'b0001000, S_ARMED,  "arm");
      step(1, 0, 1, 0, 1, PLAY, 1,  1, 7'b0001000, S_SCORED, "r030_press");
      step(1, 0, 0, 0, 1, PLAY, 0,  1, 7'b0010000, S_SCORED, "r030_after");
      step(1, 0, 1, 0, 1, PLAY, 0,  1, 7'b0010000, S_SCORED, "r033_ignored");
      step(1, 0, 0, 1, 1, PLAY, 0,  1, 7'b0010000, S_HOLD,   "r033_clr");
      step(1, 1, 0, 1, 1, PLAY, 0,  1, 7'b0010000, S_HOLD,   "hold_ignore");
      step(1, 0, 0, 0, 1, PLAY, 0,  1, 7'b0010000, S_ARMED,  "rearm");
      step(1, 1, 0, 0, 1, DARK, 1,  2, 7'b0000000, S_SCORED, "r031_dark_pbl");
      step(1, 0, 0, 0, 1, DARK, 0,  2, 7'b0000000, S_SCORED, "r031_dark_leds");
      step(1, 0, 0, 1, 1, DARK, 0,  2, 7'b0000000, S_HOLD,   "clr2");
      step(1, 0, 0, 0, 1, PLAY, 0,  2, 7'b0100000, S_ARMED,  "arm2");
      step(1, 0, 1, 0, 1, DARK, 1,  1, 7'b0000000, S_SCORED, "dark_pbr");
      step(1, 0, 0, 1, 1, PLAY, 0,  1, 7'b0010000, S_HOLD,   "clr3");
      step(1, 0, 0, 0, 1, PLAY, 0,  1, 7'b0010000, S_ARMED,  "arm3");
      step(1, 1, 1, 0, 1, PLAY, 0,  1, 7'b0010000, S_ARMED,  "r032_tie");
      step(1, 1, 0, 0, 1, PLAY, 1,  0, 7'b0010000, S_SCORED, "r032_left");
      step(1, 0, 0, 1, 1, PLAY, 0,  0, 7'b0001000, S_HOLD,   "clr4");
      step(1, 0, 0, 0, 1, PLAY, 0,  0, 7'b0001000, S_ARMED,  "arm4");
      step(1, 1, 0, 1, 1, PLAY, 0,  0, 7'b0001000, S_HOLD,   "r023_clr_press");
      step(1, 0, 0, 0, 0, PLAY, 0,  0, 7'b0000000, S_ARMED,  "leds_off");
      step(1, 0, 0, 0, 1, ALL,  0,  0, 7'b1111111, S_ARMED,  "leds_all");
      step(1, 0, 0, 0, 1, ALT,  0,  0, 7'b0001000, S_ARMED,  "leds_01");
      step(1, 1, 0, 0, 1, PLAY, 1, -1, 7'b0001000, S_SCORED, "left1");
      step(1, 0, 0, 1, 1, PLAY, 0, -1, 7'b0000100, S_HOLD,   "clr5");
      step(1, 0, 0, 0, 1, PLAY, 0, -1, 7'b0000100, S_ARMED,  "arm6");
      step(1, 1, 0, 0, 1, PLAY, 1, -2, 7'b0000100, S_SCORED, "left2");
      step(1, 0, 0, 1, 1, PLAY, 0, -2, 7'b0000010, S_HOLD,   "clr6");
      step(1, 0, 0, 0, 1, PLAY, 0, -2, 7'b0000010, S_ARMED,  "arm7");
      step(1, 1, 0, 0, 1, PLAY, 1, -3, 7'b0000010, S_MATCH,  "left3_match");
      step(1, 0, 0, 0, 1, PLAY, 0, -3, 7'b0000001, S_MATCH,  "r034_leds");
      step(1, 0, 1, 0, 1, PLAY, 0, -3, 7'b0000001, S_MATCH,  "match_pbr");
      step(1, 0, 0, 1, 1, PLAY, 0, -3, 7'b0000001, S_MATCH,  "match_clr1");
      step(1, 0, 0, 0, 1, PLAY, 0, -3, 7'b0000001, S_MATCH,  "match_clr0");
      step(1, 1, 0, 0, 1, PLAY, 0, -3, 7'b0000001, S_MATCH,  "match_pbl");
      step(1, 1, 0, 0, 1, DARK, 0, -3, 7'b0000000, S_MATCH,  "match_dark");
      step(1, 0, 0, 0, 1, ALL,  0, -3, 7'b1111111, S_MATCH,  "match_all");
      step(0, 0, 0, 0, 1, PLAY, 0,  0, 7'b0000000, S_HOLD,   "r034_reset");
      step(1, 0, 1, 0, 1, PLAY, 0,  0, 7'b0001000, S_ARMED,  "r029_first_press");
      step(1, 0, 1, 0, 1, PLAY, 1,  1, 7'b0001000, S_SCORED, "post_reset_win");
      step(1, 0, 0, 1, 1, PLAY, 0,  1, 7'b0010000, S_HOLD,   "clr7");
      step(1, 0, 0, 0, 1, PLAY, 0,  1, 7'b0010000, S_ARMED,  "arm8");
      step(0, 1, 0, 0, 1, PLAY, 0,  0, 7'b0000000, S_HOLD,   "r035_rst_press");
      step(1, 0, 1, 1, 1, PLAY, 0,  0, 7'b0001000, S_HOLD,   "r035_hold");
      step(1, 0, 0, 0, 1, PLAY, 0,  0, 7'b0001000, S_ARMED,  "r035_rearm");

      checks++;
      assert (exp_q.size() === 0) else begin
         failures++;
         $error("FAIL queue_drained got=%0d exp=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
